acq_cmd_scheduler: RTL

Sequences ADC capture requests arriving as UART command bytes from the upstream byte receiver. It decodes 'w' (waveform) and 'i' (FIR) commands and queues them. It then drives the capture datapath one request at a time through active-low acquire strobes, using the `wavenum` increment as the completion handshake. It sits between the UART RX byte decoder and the waveform/FIR capture and readout path, and has timeout, abort and overflow handling.

---
 rtl/acq_pkg.sv | 18 +
 rtl/acq_cmd_fifo.sv | 54 +++++
 rtl/acq_cmd_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/acq_pkg.sv
// Shared command encodings and FSM state type for the acquisition command scheduler.
// The 1-bit queue entry encoding is also used by the readout request path.
package acq_pkg;

  localparam logic [7:0] CMD_WAVE  = 8'h77;
  localparam logic [7:0] CMD_FIR   = 8'h69;
  localparam logic [7:0] CMD_ABORT = 8'h78;

  localparam logic ACQ_WAVE = 1'b0;
  localparam logic ACQ_FIR  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQ     = 2'd1,
    ST_HOLDOFF = 2'd2
  } acq_state_t;

endpackage

// File: rtl/acq_cmd_fifo.sv
// 1-bit synchronous FIFO with occupancy count, flush, and same-edge push/pop.
// A push while full is accepted only when a pop frees a slot on that edge.
module acq_cmd_fifo #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  push_data,
  input  logic                  pop,
  output logic                  pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH-1:0]      r_mem;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/acq_cmd_scheduler.sv
// Decodes w/i/x command bytes, queues capture requests and drives one active-low
// acquire strobe at a time, using any wavenum change as the completion handshake.
module acq_cmd_scheduler
  import acq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 72170,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int QDEPTH_LOG2    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [15:0] wavenum,
  output logic        acquireWave,
  output logic        acquireFIR,
  output logic        busy,
  output logic [7:0]  last_cmd,
  output logic        cmd_dropped,
  output logic        unknown_cmd,
  output logic        timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  acq_state_t           r_state;
  logic [15:0]          r_start_wn;
  logic [TW-1:0]        r_tcnt;
  logic [HW-1:0]        r_hcnt;
  logic                 r_acq_wave;
  logic                 r_acq_fir;
  logic [7:0]           r_last_cmd;
  logic                 r_cmd_dropped;
  logic                 r_unknown;
  logic                 r_timeout;

  logic                 w_is_wave;
  logic                 w_is_fir;
  logic                 w_abort;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_drop;
  logic                 w_accept;
  logic                 w_head;
  logic                 w_full;
  logic                 w_empty;
  logic [QDEPTH_LOG2:0] w_count;

  assign w_is_wave = rx_valid && (rx_data == CMD_WAVE);
  assign w_is_fir  = rx_valid && (rx_data == CMD_FIR);
  assign w_abort   = rx_valid && (rx_data == CMD_ABORT);
  assign w_push    = w_is_wave || w_is_fir;
  // An abort arriving while IDLE would pop a request that the flush is discarding.
  assign w_pop     = (r_state == ST_IDLE) && (w_count != '0) && !w_abort;
  assign w_drop    = w_push && w_full && !w_pop;
  assign w_accept  = w_abort || (w_push && !w_drop);

  acq_cmd_fifo #(.DEPTH_LOG2(QDEPTH_LOG2)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (w_abort),
    .push      (w_push),
    .push_data (w_is_fir ? ACQ_FIR : ACQ_WAVE),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_start_wn    <= '0;
      r_tcnt        <= '0;
      r_hcnt        <= '0;
      r_acq_wave    <= 1'b1;
      r_acq_fir     <= 1'b1;
      r_last_cmd    <= '0;
      r_cmd_dropped <= 1'b0;
      r_unknown     <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_cmd_dropped <= w_drop;
      r_unknown     <= rx_valid && !w_push && !w_abort;
      r_timeout     <= 1'b0;
      if (w_accept) r_last_cmd <= rx_data;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_start_wn <= wavenum;
            r_tcnt     <= '0;
            r_acq_wave <= (w_head != ACQ_WAVE);
            r_acq_fir  <= (w_head != ACQ_FIR);
            r_state    <= ST_ACQ;
          end
        end
        ST_ACQ: begin
          // Completion wins over a timeout landing on the same edge.
          if (w_abort || (wavenum != r_start_wn)) begin
            r_acq_wave <= 1'b1;
            r_acq_fir  <= 1'b1;
            r_hcnt     <= '0;
            r_state    <= ST_HOLDOFF;
          end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_acq_wave <= 1'b1;
            r_acq_fir  <= 1'b1;
            r_timeout  <= 1'b1;
            r_hcnt     <= '0;
            r_state    <= ST_HOLDOFF;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (r_hcnt == HW'(HOLDOFF_CYCLES - 1)) r_state <= ST_IDLE;
          else r_hcnt <= r_hcnt + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign acquireWave = r_acq_wave;
  assign acquireFIR  = r_acq_fir;
  assign busy        = (r_state != ST_IDLE) || !w_empty;
  assign last_cmd    = r_last_cmd;
  assign cmd_dropped = r_cmd_dropped;
  assign unknown_cmd = r_unknown;
  assign timeout_err = r_timeout;

endmodule
